fetch_unit: RTL and testbench
=============================

# fetch_unit

RiSC-16 instruction fetch stage: owns the program counter, fetches one 16-bit instruction per step from instruction memory over a req/ack handshake, and holds it decoded into fields for the control unit and datapath. The control unit drives `MUX_pc` from the held opcode and `EQ`. On each retire, this block applies `MUX_pc` to select the next PC. It sits directly upstream of the control unit and supplies its `op` input.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request; high only in FETCH.
- `imem_addr`  out  16  word address; equals `pc`.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  16  instruction word.
- `instr`  out  16  held instruction register.
- `op`  out  3  `instr[15:13]`; feeds control unit.
- `rA`, `rB`, `rC`  out  3 each  `instr[12:10]`, `instr[9:7]`, `instr[2:0]`.
- `simm7`  out  16  `instr[6:0]` sign-extended.
- `imm10`  out  10  `instr[9:0]`.
- `pc`  out  16  address of the held/being-fetched instruction.
- `pc_plus1`  out  16  `pc + 1` mod 2^16; used as the JALR link value.
- `instr_valid`  out  1  high in HOLD.
- `retire`  in  1  datapath finished the held instruction.
- `MUX_pc`  in  2  next-PC select: 00 = `pc+1`; 01 = `pc+1+simm7`; 10 = `jalr_tgt`; 11 = reserved, treated as 00.
- `jalr_tgt`  in  16  register value `rB` for JALR.
- `halted`  out  1  high in HALT.

## Operation
- States:
  - BOOT: reset state.
  - FETCH: `imem_req` = 1.
  - HOLD: `instr_valid` = 1.
  - HALT: `halted` = 1.
- Outputs are Moore outputs decoded from the state register.
- BOOT -> FETCH unconditionally on the first edge after `rst` falls.
- FETCH:
  - If `imem_ack` = 1 at the edge: `instr` <= `imem_rdata`, go to HOLD.
  - Otherwise stay in FETCH; `imem_addr` holds steady.
- HOLD:
  - If `retire` = 1 and the halt condition is true (`op` = 3'b111 and `instr[6:0]` != 0): go to HALT; `pc` is unchanged.
  - If `retire` = 1 and the halt condition is false: `pc` <= next PC per `MUX_pc`, go to FETCH.
  - If `retire` = 0: stay in HOLD; `instr` and `pc` are held.
- HALT: absorbing; only `rst` exits.
- `imem_ack` is ignored outside FETCH. `retire` is ignored outside HOLD.
- All PC arithmetic is 16-bit modulo 2^16; carries are discarded.
- Branch target is `pc + 1 + simm7`, where `simm7` is two's complement in the range −64..63.
- `instr` changes only on an accepted ack or on reset.

## Timing
- Reset values, asserted asynchronously:
  - state = BOOT, `pc` = `RESET_PC`, `instr` = 0.
  - `imem_req` = 0, `instr_valid` = 0, `halted` = 0.
  - Decoded fields = 0; `pc_plus1` = `RESET_PC + 1`.
- Minimum time per instruction is 2 cycles: 1 FETCH cycle with immediate ack, then 1 HOLD cycle with immediate retire.
- `instr_valid` rises in the cycle after the accepting ack edge.
- `imem_req` rises in the cycle after the retiring edge.
- Back-to-back sequence: FETCH, HOLD, FETCH, … with no bubble cycles.
- `MUX_pc` and `jalr_tgt` are sampled only at the retiring edge. They may depend combinationally on `op`.
- No combinational path exists from `imem_ack` or `retire` to any output.
- Reset mid-FETCH or mid-HOLD:
  - Immediate return to reset values; any pending ack is discarded.
  - After release, the next FETCH is at `RESET_PC`.

## Test plan
- Reset release with ack delayed 2 cycles, `imem_rdata` = 16'h2485:
  - BOOT for 1 cycle, then `imem_req` = 1 and `imem_addr` = 0 for 3 cycles.
  - Then `instr_valid` = 1, `op` = 001, `rA` = 1, `rB` = 1, `simm7` = 16'h0005.
- Sequential: retire with `MUX_pc` = 00 at `pc` = 0x0003 -> next FETCH `imem_addr` = 0x0004; `instr_valid` low for exactly 1 cycle with immediate ack.
- Branch at `pc` = 0x0005 with `instr[6:0]` = 7'h7F:
  - `MUX_pc` = 01 -> next `pc` = 0x0005.
  - With `instr[6:0]` = 7'h10 -> next `pc` = 0x0016.
- JALR and wrap:
  - `MUX_pc` = 10, `jalr_tgt` = 0x1234, `imm` = 0 -> next `pc` = 0x1234.
  - `pc` = 0xFFFF with `MUX_pc` = 00 -> next `pc` = 0x0000, and `pc_plus1` at 0xFFFF reads 0x0000.
- Halt: retire of 16'hE001 -> `halted` = 1, `imem_req` stays 0, `pc` unchanged; further `retire`/`imem_ack` pulses have no effect.
- Async reset asserted mid-FETCH at `pc` = 0x0040 with `RESET_PC` = 0x0100:
  - Outputs return to reset values with no clock edge.
  - After release, first `imem_addr` = 0x0100.
  - An ack coinciding with `rst` is discarded.

Source files
------------

// File: rtl/fetch_unit.sv
// RiSC-16 instruction fetch stage: owns the PC, fetches one instruction per step
// over a req/ack handshake and holds it decoded for the control unit and datapath.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [2:0]  op,
  output logic [2:0]  rA,
  output logic [2:0]  rB,
  output logic [2:0]  rC,
  output logic [15:0] simm7,
  output logic [9:0]  imm10,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic        instr_valid,
  input  logic        retire,
  input  logic [1:0]  MUX_pc,
  input  logic [15:0] jalr_tgt,
  output logic        halted
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;

  logic [15:0] w_pc_plus1;
  logic [15:0] w_simm7;
  logic [15:0] w_next_pc;
  logic        w_halt;

  assign w_pc_plus1 = r_pc + 16'd1;
  assign w_simm7    = {{9{r_instr[6]}}, r_instr[6:0]};
  assign w_halt     = (r_instr[15:13] == 3'b111) && (r_instr[6:0] != 7'd0);

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    w_next_pc = w_pc_plus1;
    case (MUX_pc)
      2'b01:   w_next_pc = w_pc_plus1 + w_simm7;
      2'b10:   w_next_pc = jalr_tgt;
      default: w_next_pc = w_pc_plus1;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_instr <= 16'd0;
    end else begin
      case (r_state)
        S_BOOT:  r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (retire) begin
            if (w_halt) begin
              r_state <= S_HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= S_FETCH;
            end
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Moore outputs: nothing here depends on imem_ack or retire.
  assign imem_req    = (r_state == S_FETCH);
  assign instr_valid = (r_state == S_HOLD);
  assign halted      = (r_state == S_HALT);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus1    = w_pc_plus1;
  assign instr       = r_instr;
  assign op          = r_instr[15:13];
  assign rA          = r_instr[12:10];
  assign rB          = r_instr[9:7];
  assign rC          = r_instr[2:0];
  assign simm7       = w_simm7;
  assign imm10       = r_instr[9:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a state-level model predicts fetch addresses,
// held-instruction fields and halts; a separate monitor compares them as the DUT shows them.
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [2:0]  op, rA, rB, rC;
  logic [15:0] simm7;
  logic [9:0]  imm10;
  logic [15:0] pc, pc_plus1;
  logic        instr_valid;
  logic        retire;
  logic [1:0]  MUX_pc;
  logic [15:0] jalr_tgt;
  logic        halted;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .rA(rA), .rB(rB), .rC(rC), .simm7(simm7), .imm10(imm10),
    .pc(pc), .pc_plus1(pc_plus1), .instr_valid(instr_valid), .retire(retire),
    .MUX_pc(MUX_pc), .jalr_tgt(jalr_tgt), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef enum {M_BOOT, M_FETCH, M_HOLD, M_HALT} mstate_t;
  typedef struct {
    logic [15:0] instr;
    logic [2:0]  op, ra, rb, rc;
    logic [15:0] simm7;
    logic [9:0]  imm10;
    logic [15:0] pc, pc_plus1;
  } hold_t;

  int n_cmp = 0;
  int n_err = 0;

  mstate_t     m_state;
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] q_fetch[$];
  hold_t       q_hold[$];
  logic [15:0] q_halt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic missing(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT output with no expectation queued (t=%0t)", name, $time);
  endtask

  // Reference arithmetic straight from the ISA rules, on plain integers.
  function automatic int sext7(input logic [15:0] ins);
    int v = int'(ins) % 128;
    return (v >= 64) ? v - 128 : v;
  endfunction

  function automatic logic [15:0] model_next_pc(input logic [15:0] p, input logic [15:0] ins,
                                                input logic [1:0] sel, input logic [15:0] jt);
    int r;
    case (sel)
      2'd1:    r = (int'(p) + 1 + sext7(ins) + 65536) % 65536;
      2'd2:    r = int'(jt);
      default: r = (int'(p) + 1) % 65536;
    endcase
    return 16'(r);
  endfunction

  function automatic hold_t make_hold(input logic [15:0] ins, input logic [15:0] p);
    hold_t h;
    h.instr    = ins;
    h.op       = 3'(int'(ins) / 8192);
    h.ra       = 3'((int'(ins) / 1024) % 8);
    h.rb       = 3'((int'(ins) / 128) % 8);
    h.rc       = 3'(int'(ins) % 8);
    h.simm7    = 16'(sext7(ins));
    h.imm10    = 10'(int'(ins) % 1024);
    h.pc       = p;
    h.pc_plus1 = 16'((int'(p) + 1) % 65536);
    return h;
  endfunction

  task automatic model_reset();
    m_state = M_BOOT;
    m_pc    = RST_PC;
    m_instr = 16'd0;
    q_fetch.delete();
    q_hold.delete();
    q_halt.delete();
  endtask

  // Drive one cycle's inputs at the falling edge and advance the model across the next rising edge.
  task automatic step(input bit ack, input logic [15:0] rd, input bit ret,
                      input logic [1:0] mux, input logic [15:0] jt);
    @(negedge clk);
    rst        = 1'b0;
    imem_ack   = ack;
    imem_rdata = rd;
    retire     = ret;
    MUX_pc     = mux;
    jalr_tgt   = jt;
    case (m_state)
      M_BOOT: begin
        m_state = M_FETCH;
        q_fetch.push_back(m_pc);
      end
      M_FETCH: if (ack) begin
        m_instr = rd;
        q_hold.push_back(make_hold(m_instr, m_pc));
        m_state = M_HOLD;
      end
      M_HOLD: if (ret) begin
        if ((int'(m_instr) / 8192 == 7) && (int'(m_instr) % 128 != 0)) begin
          q_halt.push_back(m_pc);
          m_state = M_HALT;
        end else begin
          m_pc = model_next_pc(m_pc, m_instr, mux, jt);
          q_fetch.push_back(m_pc);
          m_state = M_FETCH;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},      32'(imem_req), 32'd0);
    check({tag, "_valid"},    32'(instr_valid), 32'd0);
    check({tag, "_halted"},   32'(halted), 32'd0);
    check({tag, "_pc"},       32'(pc), 32'(RST_PC));
    check({tag, "_pc_plus1"}, 32'(pc_plus1), 32'(RST_PC + 16'd1));
    check({tag, "_instr"},    32'(instr), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0; imem_rdata = 16'd0; retire = 1'b0; MUX_pc = 2'd0; jalr_tgt = 16'd0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // Assert reset between edges; the next step() releases it.
  task automatic mid_reset();
    #1 rst = 1'b1;
    model_reset();
    #1 check_reset_outputs("async_rst");
  endtask

  // Monitor: pops an expectation each time the DUT presents a new fetch, held instruction or halt.
  logic        p_req, p_valid, p_halt;
  logic [15:0] mon_addr;
  hold_t       h;
  always @(negedge clk) begin
    if (rst) begin
      p_req = 1'b0; p_valid = 1'b0; p_halt = 1'b0;
    end else begin
      if (imem_req && !p_req) begin
        if (q_fetch.size() == 0) missing("fetch");
        else begin
          mon_addr = q_fetch.pop_front();
          check("fetch_addr", 32'(imem_addr), 32'(mon_addr));
        end
      end else if (imem_req) begin
        check("fetch_addr_steady", 32'(imem_addr), 32'(mon_addr));
      end
      if (instr_valid && !p_valid) begin
        if (q_hold.size() == 0) missing("hold");
        else begin
          h = q_hold.pop_front();
          check("hold_instr", 32'(instr), 32'(h.instr));
          check("hold_op", 32'(op), 32'(h.op));
          check("hold_rA", 32'(rA), 32'(h.ra));
          check("hold_rB", 32'(rB), 32'(h.rb));
          check("hold_rC", 32'(rC), 32'(h.rc));
          check("hold_simm7", 32'(simm7), 32'(h.simm7));
          check("hold_imm10", 32'(imm10), 32'(h.imm10));
          check("hold_pc", 32'(pc), 32'(h.pc));
          check("hold_pc_plus1", 32'(pc_plus1), 32'(h.pc_plus1));
        end
      end
      if (halted && !p_halt) begin
        if (q_halt.size() == 0) missing("halt");
        else check("halt_pc", 32'(pc), 32'(q_halt.pop_front()));
      end
      p_req = imem_req; p_valid = instr_valid; p_halt = halted;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd, jt;
    int halt_wait;

    // Reset state, then a fetch acknowledged on its third cycle.
    do_reset();
    check_reset_outputs("reset");
    check("reset_op", 32'(op), 32'd0);
    check("reset_simm7", 32'(simm7), 32'd0);
    check("reset_imm10", 32'(imm10), 32'd0);
    step(0, 16'd0, 0, 2'd0, 16'd0);
    check("boot_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(i == 2, 16'h2485, 0, 2'd0, 16'd0);
      check("first_fetch_req", 32'(imem_req), 32'd1);
      check("first_fetch_addr", 32'(imem_addr), 32'(RST_PC));
    end
    step(0, 16'd0, 0, 2'd0, 16'd0);
    check("first_req_drop", 32'(imem_req), 32'd0);
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_op", 32'(op), 32'd1);
    check("first_rA", 32'(rA), 32'd1);
    check("first_rB", 32'(rB), 32'd1);
    check("first_simm7", 32'(simm7), 32'h0005);

    // Sequential step from 0x0003 with one-cycle bubble.
    step(0, 16'd0, 1, 2'd2, 16'h0003);
    step(1, 16'h0000, 0, 2'd0, 16'd0);
    check("seq_fetch_addr", 32'(imem_addr), 32'h0003);
    step(0, 16'd0, 1, 2'd0, 16'd0);
    check("seq_hold_pc", 32'(pc), 32'h0003);
    step(1, 16'h0000, 0, 2'd0, 16'd0);
    check("seq_valid_low", 32'(instr_valid), 32'd0);
    check("seq_next_addr", 32'(imem_addr), 32'h0004);

    // Branches at 0x0005: offset -1 loops to itself, offset +16 lands at 0x0016.
    step(0, 16'd0, 1, 2'd0, 16'd0);
    check("seq_valid_back", 32'(instr_valid), 32'd1);
    step(1, 16'hC07F, 0, 2'd0, 16'd0);
    check("br_fetch_addr", 32'(imem_addr), 32'h0005);
    step(0, 16'd0, 1, 2'd1, 16'd0);
    check("br_simm7_neg", 32'(simm7), 32'hFFFF);
    step(1, 16'hC010, 0, 2'd0, 16'd0);
    check("br_self_addr", 32'(imem_addr), 32'h0005);
    step(0, 16'd0, 1, 2'd1, 16'd0);
    check("br_instr", 32'(instr), 32'hC010);
    step(1, 16'hE480, 0, 2'd0, 16'd0);
    check("br_fwd_addr", 32'(imem_addr), 32'h0016);

    // JALR, then wrap from 0xFFFF.
    step(0, 16'd0, 1, 2'd2, 16'h1234);
    check("jalr_op", 32'(op), 32'd7);
    step(1, 16'h0000, 0, 2'd0, 16'd0);
    check("jalr_addr", 32'(imem_addr), 32'h1234);
    step(0, 16'd0, 1, 2'd2, 16'hFFFF);
    step(1, 16'h0000, 0, 2'd0, 16'd0);
    check("wrap_addr_top", 32'(imem_addr), 32'hFFFF);
    step(0, 16'd0, 1, 2'd0, 16'd0);
    check("wrap_pc_plus1", 32'(pc_plus1), 32'h0000);
    step(1, 16'hE001, 0, 2'd0, 16'd0);
    check("wrap_addr", 32'(imem_addr), 32'h0000);

    // Halt is absorbing.
    step(0, 16'd0, 1, 2'd2, 16'h5555);
    check("halt_hold_op", 32'(op), 32'd7);
    for (int i = 0; i < 4; i++) begin
      step(1, 16'($urandom), 1, 2'($urandom_range(0, 3)), 16'($urandom));
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_pc_kept", 32'(pc), 32'h0000);
      check("halt_instr_kept", 32'(instr), 32'hE001);
    end

    // Async reset mid-FETCH at 0x0040 with an ack landing during reset.
    do_reset();
    step(0, 16'd0, 0, 2'd0, 16'd0);
    step(1, 16'h0000, 0, 2'd0, 16'd0);
    step(0, 16'd0, 1, 2'd2, 16'h0040);
    step(0, 16'd0, 0, 2'd0, 16'd0);
    check("pre_rst_addr", 32'(imem_addr), 32'h0040);
    imem_ack = 1'b1;
    imem_rdata = 16'hABCD;
    mid_reset();
    @(posedge clk);
    #1 check("rst_ack_discard", 32'(instr), 32'd0);
    step(0, 16'd0, 0, 2'd0, 16'd0);
    step(0, 16'd0, 0, 2'd0, 16'd0);
    check("post_rst_addr", 32'(imem_addr), 32'(RST_PC));
    check("post_rst_instr", 32'(instr), 32'd0);

    // Randomized traffic, including stray ack/retire, reserved MUX_pc, halts and resets.
    halt_wait = 0;
    for (int i = 0; i < 3000; i++) begin
      rd = 16'($urandom);
      if (rd[15:13] == 3'b111 && $urandom_range(0, 9) != 0) rd[6:0] = 7'd0;
      jt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step(1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), jt);
      if (m_state == M_HALT) halt_wait++;
      if (halt_wait > 3 || $urandom_range(0, 299) == 0) begin
        mid_reset();
        halt_wait = 0;
      end
    end

    step(0, 16'd0, 0, 2'd0, 16'd0);
    step(0, 16'd0, 0, 2'd0, 16'd0);
    @(posedge clk);
    #1;
    check("q_fetch_drained", 32'(q_fetch.size()), 32'd0);
    check("q_hold_drained", 32'(q_hold.size()), 32'd0);
    check("q_halt_drained", 32'(q_halt.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
